// File: rtl/ab_seq_pkg.sv
// Shared types and constants for the A/B trigger-sequence generator.
package ab_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StFire,
    StGap,
    StDone
  } ab_state_e;

  // Rest pattern that holds the downstream detector idle.
  localparam logic A_IDLE = 1'b1;
  localparam logic B_IDLE = 1'b0;

  localparam int unsigned MIN_GAP = 1;

endpackage

// File: rtl/ab_seq_checker.sv
// Loopback comparator: expects detector Q exactly in the cycle after each FIRE while busy,
// and keeps a sticky error flag plus a saturating mismatch count.
module ab_seq_checker #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             busy_i,
  input  logic             fire_d1_i,
  input  logic             q_i,
  output logic             err_o,
  output logic [CNT_W-1:0] err_count_o
);

  logic             err_q, err_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             mismatch;

  always_comb begin
    err_d       = err_q;
    err_count_d = err_count_q;
    mismatch    = busy_i && (q_i != fire_d1_i);
    if (mismatch) begin
      err_d = 1'b1;
      if (err_count_q != {CNT_W{1'b1}}) begin
        err_count_d = err_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign err_o       = err_q;
  assign err_count_o = err_count_q;

endmodule

// File: rtl/ab_seq_gen.sv
// A/B trigger-frame generator: emits `count` frames of A-low, B-high, then an idle gap.
// Optional loopback checking of detector Q is built when LOOPBACK_CHECK_EN is defined.
module ab_seq_gen
  import ab_seq_pkg::*;
#(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned GAP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
`ifdef LOOPBACK_CHECK_EN
  input  logic             q_in,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
`endif
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic [GAP_W-1:0] gap,
  output logic             a_out,
  output logic             b_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frames_sent
);

  ab_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] frames_q, frames_d;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    frames_d  = frames_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          count_d  = count;
          // Zero gap would put the next A-low in the detector's blind Q cycle.
          gap_d    = (gap == '0) ? GAP_W'(MIN_GAP) : gap;
          frames_d = '0;
          state_d  = (count == '0) ? StDone : StArm;
        end
      end
      StArm:  state_d = StFire;
      StFire: begin
        frames_d  = frames_q + CNT_W'(1);
        gap_cnt_d = gap_q - GAP_W'(1);
        state_d   = StGap;
      end
      StGap: begin
        if (gap_cnt_q == '0) begin
          state_d = (frames_q < count_q) ? StArm : StDone;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      count_q   <= '0;
      gap_q     <= GAP_W'(MIN_GAP);
      gap_cnt_q <= '0;
      frames_q  <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      frames_q  <= frames_d;
    end
  end

  always_comb begin
    a_out = (state_q == StArm) ? ~A_IDLE : A_IDLE;
    b_out = (state_q == StFire) ? ~B_IDLE : B_IDLE;
    busy  = (state_q != StIdle);
    done  = (state_q == StDone);
  end

  assign frames_sent = frames_q;

`ifdef LOOPBACK_CHECK_EN
  logic fire_d1_q, fire_d1_d;

  assign fire_d1_d = (state_q == StFire);

  always_ff @(posedge clk) begin
    if (!reset) begin
      fire_d1_q <= 1'b0;
    end else begin
      fire_d1_q <= fire_d1_d;
    end
  end

  ab_seq_checker #(
    .CNT_W (CNT_W)
  ) u_checker (
    .clk_i       (clk),
    .rst_ni      (reset),
    .busy_i      (busy),
    .fire_d1_i   (fire_d1_q),
    .q_i         (q_in),
    .err_o       (err),
    .err_count_o (err_count)
  );
`endif

endmodule

// File: tb/tb_ab_seq_gen.sv
// Randomized self-checking bench for ab_seq_gen; expected waveforms are computed from the
// frame timing formulas (period = 2 + max(gap,1)), not from a state machine.
module tb_ab_seq_gen;

  localparam int CNT_W = 8;
  localparam int GAP_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] count;
  logic [GAP_W-1:0] gap;
  logic             a_out, b_out, busy, done;
  logic [CNT_W-1:0] frames_sent;
  logic             q_det;
  logic             a_low_q;
  logic             q_tie0;
  logic             q_in;
  logic             err;
  logic [CNT_W-1:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign q_in = q_tie0 ? 1'b0 : q_det;

  ab_seq_gen #(
    .CNT_W (CNT_W),
    .GAP_W (GAP_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
`ifdef LOOPBACK_CHECK_EN
    .q_in        (q_in),
    .err         (err),
    .err_count   (err_count),
`endif
    .start       (start),
    .count       (count),
    .gap         (gap),
    .a_out       (a_out),
    .b_out       (b_out),
    .busy        (busy),
    .done        (done),
    .frames_sent (frames_sent)
  );

`ifndef LOOPBACK_CHECK_EN
  assign err       = 1'b0;
  assign err_count = '0;
`endif

  // Behavioural detector: Q one cycle after A-low is followed by B-high.
  always @(posedge clk) begin
    if (!reset) begin
      a_low_q <= 1'b0;
      q_det   <= 1'b0;
    end else begin
      a_low_q <= ~a_out;
      q_det   <= a_low_q & b_out & ~q_det;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input int fr);
    check_val({tag, " a_out"}, 32'(a_out), 32'd1);
    check_val({tag, " b_out"}, 32'(b_out), 32'd0);
    check_val({tag, " busy"}, 32'(busy), 32'd0);
    check_val({tag, " done"}, 32'(done), 32'd0);
    check_val({tag, " frames"}, 32'(frames_sent), 32'(fr));
  endtask

  // Start a run at cycle 0 and check every cycle 1..D+1 against the timing formulas.
  task automatic run_seq(input int c, input int g, input bit hold_start);
    int eff, period, d, k, fr;
    bit exp_a, exp_b, exp_busy, exp_done, exp_q;
    eff    = (g == 0) ? 1 : g;
    period = 2 + eff;
    d      = 1 + c * period;
    count  = CNT_W'(c);
    gap    = GAP_W'(g);
    start  = 1'b1;
    tick();
    if (!hold_start) start = 1'b0;
    for (int t = 1; t <= d + 1; t++) begin
      exp_a = 1'b1; exp_b = 1'b0; exp_busy = 1'b0; exp_done = 1'b0; exp_q = 1'b0;
      fr = c;
      if (t < d) begin
        k        = (t - 1) % period;
        exp_busy = 1'b1;
        exp_a    = (k != 0);
        exp_b    = (k == 1);
        exp_q    = (k == 2);
        fr       = (t - 1) / period + ((k >= 2) ? 1 : 0);
      end else if (t == d) begin
        exp_busy = 1'b1;
        exp_done = 1'b1;
      end
      check_val("a_out", 32'(a_out), 32'(exp_a));
      check_val("b_out", 32'(b_out), 32'(exp_b));
      check_val("busy", 32'(busy), 32'(exp_busy));
      check_val("done", 32'(done), 32'(exp_done));
      check_val("frames_sent", 32'(frames_sent), 32'(fr));
      check_val("detector_q", 32'(q_det), 32'(exp_q));
      // Scramble inputs while busy: latched values must be unaffected.
      count = CNT_W'($urandom);
      gap   = GAP_W'($urandom);
      if (t >= d - 1) start = 1'b0;
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset  = 1'b0;
    start  = 1'b0;
    count  = '0;
    gap    = '0;
    q_tie0 = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_idle("reset_idle", 0);
      tick();
    end

    run_seq(2, 3, 1'b0);
    check_idle("after_2_3", 2);
    run_seq(3, 0, 1'b0);
    run_seq(0, 0, 1'b0);
    check_idle("after_count0", 0);
    run_seq(4, 1, 1'b1);
    check_idle("after_held_start", 4);

    // Reset asserted during cycle 4 of a count=5, gap=2 run.
    count = 8'd5;
    gap   = 4'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      check_val("pre_reset busy", 32'(busy), 32'd1);
      if (t == 4) begin
        reset = 1'b0;
        start = 1'b1;
      end
      tick();
    end
    start = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_idle("abort", 0);
      tick();
    end

    for (int it = 0; it < 12; it++) begin
      int c, g;
      c = int'($urandom_range(0, 6));
      g = int'($urandom_range(0, 7));
      run_seq(c, g, 1'($urandom_range(0, 1)));
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
        check_idle("rand_gap_idle", c);
        tick();
      end
    end

    run_seq(255, 0, 1'b0);
    check_idle("after_full_count", 255);

`ifdef LOOPBACK_CHECK_EN
    check_val("loopback err clean", 32'(err), 32'd0);
    check_val("loopback err_count clean", 32'(err_count), 32'd0);
    reset = 1'b0;
    tick();
    reset  = 1'b1;
    q_tie0 = 1'b1;
    count  = 8'd3;
    gap    = 4'd2;
    start  = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40 && busy; i++) tick();
    check_val("tied err", 32'(err), 32'd1);
    check_val("tied err_count", 32'(err_count), 32'd3);
    q_tie0 = 1'b0;
    run_seq(2, 1, 1'b0);
    check_val("err sticky over start", 32'(err), 32'd1);
    check_val("err_count held", 32'(err_count), 32'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
